fft_data_input_handler: RTL and testbench
=========================================

FFT_DATA_INPUT_HANDLER -- requirements
Module: fft_data_input_handler

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024, meaning transform points per frame; power of two, 8..65536.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning sample buffer entries; power of two, 4..256.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sample  input  16  signed two's-complement audio sample from the ADC path.
REQ-006 SHALL have port sampleValid  input  1  one-cycle strobe meaning sample is valid this cycle.
REQ-007 SHALL have port tData  output  32  FFT input word: [15:0] real = sample, [31:16] imaginary = 16'h0000.
REQ-008 SHALL have port tValid  output  1  tData and tLast hold a valid transfer.
REQ-009 SHALL have port tLast  output  1  current transfer is point FRAME_LEN-1 of a frame.
REQ-010 SHALL have port tReady  input  1  FFT core accepts the transfer this cycle.
REQ-011 SHALL have port level  output  log2(FIFO_DEPTH)+1  number of samples currently buffered.
REQ-012 SHALL have port overflow  output  1  sticky flag: at least one sample was dropped since reset.

Function
REQ-013 SHALL buffer samples in a first-word-fall-through FIFO of FIFO_DEPTH entries.
REQ-014 SHALL push: a sampleValid cycle writes sample at the tail on that rising edge, if space exists.
REQ-015 SHALL pop: a handshake is tValid && tReady sampled high on a rising edge; the head entry is removed on that edge.
REQ-016 SHALL drive tValid = (level != 0); tData = {16'h0000, head sample}.
REQ-017 SHALL give latency: a sample pushed into an empty FIFO on edge k is presented with tValid=1 immediately after edge k, i.e. one cycle.
REQ-018 SHALL hold tData and tLast stable while tValid=1 and tReady=0; tValid SHALL NOT deassert without a handshake.
REQ-019 SHALL keep a point counter idx, 0..FRAME_LEN-1, incremented on each handshake and wrapping from FRAME_LEN-1 to 0.
REQ-020 SHALL drive tLast = tValid && (idx == FRAME_LEN-1); it is combinational from registered state.
REQ-021 SHALL, with push and pop on the same edge, accept both; level is unchanged, including when level == FIFO_DEPTH.
REQ-022 SHALL, on a push with level == FIFO_DEPTH and no pop on that edge, drop the sample; FIFO contents and idx are unchanged and overflow is set to 1.
REQ-023 SHALL hold overflow at 1 until RST; it does not alter framing.
REQ-024 SHALL, when level == 0, ignore tReady: no pop occurs and idx is unchanged.
REQ-025 SHALL update level as +1 on push-only, -1 on pop-only, and 0 otherwise; it never exceeds FIFO_DEPTH or goes below 0.
REQ-026 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH, with no loss at the wrap.

Reset
REQ-027 SHALL, on RST high at a rising edge: level=0, tValid=0, tLast=0, idx=0, overflow=0, pointers=0; tData is don't-care but SHALL read 32'h0.
REQ-028 SHALL give RST priority over simultaneous push and pop; buffered samples are discarded and the next frame starts at idx 0.
REQ-029 SHALL, on reset asserted mid-frame, start the first transfer after release with idx=0; no tLast appears before FRAME_LEN further handshakes.
REQ-030 SHALL hold outputs at their reset values while RST stays high, even if sampleValid or tReady is high.

Verification
REQ-031 SHALL cover basic transfer: FRAME_LEN=8, tReady=1, push 0x0001..0x0008 on every 4th cycle -> tData 0x00000001..0x00000008 each one cycle after its push, tLast only with 0x00000008.
REQ-032 SHALL cover backpressure: tReady=0 for 20 cycles while pushing 5 samples -> tValid=1, tData stays 0x00000001, level=5; tReady=1 then drains in order.
REQ-033 SHALL cover overflow: FIFO_DEPTH=4, tReady=0, push 6 samples A..F -> level=4, overflow=1, and the drain yields A,B,C,D only.
REQ-034 SHALL cover full with simultaneous push and pop: level=4, tReady=1, push G on the same edge -> level stays 4, G is accepted, overflow unchanged.
REQ-035 SHALL cover frame wrap: FRAME_LEN=8, stream 24 samples -> tLast on transfers 8, 16 and 24 only.
REQ-036 SHALL cover mid-frame reset: RST for 1 cycle after 3 handshakes, then 8 pushes -> tLast on the 8th post-reset transfer, level=0 right after reset.

Source files
------------

// File: rtl/fft_data_input_handler.sv
// Buffers ADC samples in a first-word-fall-through FIFO and presents them as
// complex FFT input transfers, marking the last point of each frame with tLast.
module fft_data_input_handler #(
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [15:0]                 sample,
  input  logic                        sampleValid,
  output logic [31:0]                 tData,
  output logic                        tValid,
  output logic                        tLast,
  input  logic                        tReady,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtrReg, wrPtrNext;
  logic [AW-1:0] rdPtrReg, rdPtrNext;
  logic [LW-1:0] levelReg, levelNext;
  logic [IW-1:0] idxReg, idxNext;
  logic          overflowReg, overflowNext;
  logic [15:0]   headReg;
  logic          full, push, pop, wrEn;

  always_comb begin
    full         = (levelReg == DEPTH_L);
    pop          = (levelReg != '0) && tReady;
    push         = sampleValid;
    // A full FIFO still accepts a sample when the head leaves on the same edge
    wrEn         = push && (!full || pop) && !RST;
    wrPtrNext    = wrPtrReg;
    rdPtrNext    = rdPtrReg;
    levelNext    = levelReg;
    idxNext      = idxReg;
    overflowNext = overflowReg;
    if (wrEn) begin
      wrPtrNext = wrPtrReg + AW'(1);
    end
    if (pop) begin
      rdPtrNext = rdPtrReg + AW'(1);
      idxNext   = (idxReg == LAST_IDX) ? '0 : idxReg + IW'(1);
    end
    case ({wrEn, pop})
      2'b10:   levelNext = levelReg + LW'(1);
      2'b01:   levelNext = levelReg - LW'(1);
      default: levelNext = levelReg;
    endcase
    if (push && full && !pop) begin
      overflowNext = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wrEn) begin
      mem[wrPtrReg] <= sample;
    end
  end

  // Head register reads the entry that will be at the head after this edge,
  // bypassing the write port when that entry is being written right now.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      levelReg    <= '0;
      idxReg      <= '0;
      overflowReg <= 1'b0;
      headReg     <= '0;
    end else begin
      wrPtrReg    <= wrPtrNext;
      rdPtrReg    <= rdPtrNext;
      levelReg    <= levelNext;
      idxReg      <= idxNext;
      overflowReg <= overflowNext;
      headReg     <= (wrEn && (wrPtrReg == rdPtrNext)) ? sample : mem[rdPtrNext];
    end
  end

  always_comb begin
    tValid   = (levelReg != '0);
    tData    = tValid ? {16'h0000, headReg} : 32'h0;
    tLast    = tValid && (idxReg == LAST_IDX);
    level    = levelReg;
    overflow = overflowReg;
  end

endmodule

// File: tb/tb_fft_data_input_handler.sv
// Drives two handler instances (depth 8 and depth 4, frame 8) with shared stimulus and
// compares them every cycle against a queue-based reference plus directed expectations.
module tb_fft_data_input_handler;

  localparam int FRAME = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] sample = '0;
  logic        sampleValid = 1'b0;
  logic        tReady = 1'b0;

  logic [31:0] tData0, tData1;
  logic        tValid0, tValid1, tLast0, tLast1, overflow0, overflow1;
  logic [3:0]  level0;
  logic [2:0]  level1;

  always #5 CLK = ~CLK;

  fft_data_input_handler #(.FRAME_LEN(FRAME), .FIFO_DEPTH(8)) dut0 (
    .CLK(CLK), .RST(RST), .sample(sample), .sampleValid(sampleValid),
    .tData(tData0), .tValid(tValid0), .tLast(tLast0), .tReady(tReady),
    .level(level0), .overflow(overflow0)
  );

  fft_data_input_handler #(.FRAME_LEN(FRAME), .FIFO_DEPTH(4)) dut1 (
    .CLK(CLK), .RST(RST), .sample(sample), .sampleValid(sampleValid),
    .tData(tData1), .tValid(tValid1), .tLast(tLast1), .tReady(tReady),
    .level(level1), .overflow(overflow1)
  );

  // Reference model: one queue of buffered samples per instance
  logic [15:0] mq [2][$];
  int          midx [2];
  bit          movf [2];
  int          nChecks = 0;
  int          nFail = 0;
  int          hsCount = 0;
  logic [31:0] lastMask = '0;

  function automatic int depthOf(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic modelStep(input bit r, input bit v, input logic [15:0] s, input bit rdy);
    int  sz;
    bit  popped;
    bit  wasFull;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mq[i].delete();
        midx[i] = 0;
        movf[i] = 1'b0;
      end else begin
        sz      = mq[i].size();
        popped  = (sz > 0) && rdy;
        wasFull = (sz == depthOf(i));
        if (popped) begin
          void'(mq[i].pop_front());
          midx[i] = (midx[i] + 1) % FRAME;
        end
        if (v) begin
          if (!wasFull || popped) mq[i].push_back(s);
          else movf[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic checkModel();
    logic [31:0] d, expD;
    logic        v, l, o, expV;
    int          lv;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        d = tData0; v = tValid0; l = tLast0; o = overflow0; lv = int'(level0);
      end else begin
        d = tData1; v = tValid1; l = tLast1; o = overflow1; lv = int'(level1);
      end
      expV = (mq[i].size() > 0);
      expD = expV ? {16'h0000, mq[i][0]} : 32'h0;
      chk($sformatf("model%0d_tValid", i), 32'(v), 32'(expV));
      chk($sformatf("model%0d_tData", i), d, expD);
      chk($sformatf("model%0d_tLast", i), 32'(l), 32'(expV && (midx[i] == FRAME - 1)));
      chk($sformatf("model%0d_level", i), 32'(lv), 32'(mq[i].size()));
      chk($sformatf("model%0d_overflow", i), 32'(o), 32'(movf[i]));
    end
  endtask

  // One clock cycle: drive inputs, log the handshake (instance 0) about to happen,
  // advance the model at the edge, compare just after it.
  task automatic step(input bit r, input bit v, input logic [15:0] s, input bit rdy);
    RST = r; sampleValid = v; sample = s; tReady = rdy;
    #1;
    if (!r && tValid0 && rdy) begin
      hsCount++;
      if (tLast0 && hsCount < 32) lastMask[hsCount] = 1'b1;
      $display("xfer inst0 n=%0d data=%h last=%b", hsCount, tData0, tLast0);
    end
    @(posedge CLK);
    modelStep(r, v, s, rdy);
    #1;
    checkModel();
  endtask

  typedef struct {
    bit          rst;
    bit          v;
    logic [15:0] s;
    bit          rdy;
    int          lvl;
    bit          val;
    logic [31:0] dat;
    bit          last;
    bit          ovf;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // Vectors for the depth-4 instance: fill, overflow, full push+pop, idle tReady, frame end
    tbl[0]  = '{1'b1, 1'b1, 16'h1111, 1'b1, 0, 1'b0, 32'h0,      1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 1, 1'b1, 32'h1111,   1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h2222, 1'b0, 2, 1'b1, 32'h1111,   1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 16'h3333, 1'b0, 3, 1'b1, 32'h1111,   1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'h4444, 1'b0, 4, 1'b1, 32'h1111,   1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'h5555, 1'b0, 4, 1'b1, 32'h1111,   1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 16'h6666, 1'b1, 4, 1'b1, 32'h2222,   1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3, 1'b1, 32'h3333,   1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 2, 1'b1, 32'h4444,   1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1, 1'b1, 32'h6666,   1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 32'h0,      1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 32'h0,      1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 16'h7777, 1'b0, 1, 1'b1, 32'h7777,   1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 32'h0,      1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 16'h8888, 1'b0, 1, 1'b1, 32'h8888,   1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 32'h0,      1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 16'h9999, 1'b0, 1, 1'b1, 32'h9999,   1'b1, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 32'h0,      1'b0, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 16'hABCD, 1'b1, 0, 1'b0, 32'h0,      1'b0, 1'b0};

    for (int r = 0; r < 19; r++) begin
      step(tbl[r].rst, tbl[r].v, tbl[r].s, tbl[r].rdy);
      chk($sformatf("tbl%0d_level", r), 32'(level1), 32'(tbl[r].lvl));
      chk($sformatf("tbl%0d_tValid", r), 32'(tValid1), 32'(tbl[r].val));
      chk($sformatf("tbl%0d_tData", r), tData1, tbl[r].dat);
      chk($sformatf("tbl%0d_tLast", r), 32'(tLast1), 32'(tbl[r].last));
      chk($sformatf("tbl%0d_overflow", r), 32'(overflow1), 32'(tbl[r].ovf));
    end

    // Basic transfer: push every 4th cycle, each sample out one cycle later
    step(1, 0, 16'h0, 0);
    hsCount = 0; lastMask = '0;
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 16'(k), 1);
      chk("basic_tValid", 32'(tValid0), 32'h1);
      chk("basic_tData", tData0, 32'(k));
      chk("basic_tLast", 32'(tLast0), 32'(k == 8));
      repeat (3) step(0, 0, 16'h0, 1);
    end
    chk("basic_hsCount", 32'(hsCount), 32'd8);
    chk("basic_lastMask", lastMask, 32'h1 << 8);

    // Backpressure: 5 pushes over 20 cycles with tReady low, then drain in order
    step(1, 0, 16'h0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 16'(k), 0);
      chk("bp_tValid", 32'(tValid0), 32'h1);
      chk("bp_tData", tData0, 32'h1);
      for (int j = 0; j < 3; j++) begin
        step(0, 0, 16'h0, 0);
        chk("bp_hold_tData", tData0, 32'h1);
      end
    end
    chk("bp_level", 32'(level0), 32'd5);
    for (int j = 1; j <= 5; j++) begin
      chk("bp_drain_tData", tData0, 32'(j));
      step(0, 0, 16'h0, 1);
    end
    chk("bp_empty_tValid", 32'(tValid0), 32'h0);

    // Overflow on the depth-4 instance: A..F pushed, only A..D survive
    step(1, 0, 16'h0, 0);
    for (int k = 0; k < 6; k++) step(0, 1, 16'(16'h000A + k), 0);
    chk("ovf_level", 32'(level1), 32'd4);
    chk("ovf_flag", 32'(overflow1), 32'h1);
    for (int j = 0; j < 4; j++) begin
      chk("ovf_drain_tData", tData1, 32'(16'h000A + j));
      step(0, 0, 16'h0, 1);
    end
    chk("ovf_empty_tValid", 32'(tValid1), 32'h0);
    chk("ovf_sticky", 32'(overflow1), 32'h1);

    // Full FIFO with simultaneous push and pop
    step(1, 0, 16'h0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 16'(16'h00A0 + k), 0);
    chk("fullpp_level_before", 32'(level1), 32'd4);
    step(0, 1, 16'h00C7, 1);
    chk("fullpp_level_after", 32'(level1), 32'd4);
    chk("fullpp_overflow", 32'(overflow1), 32'h0);
    for (int j = 0; j < 4; j++) begin
      chk("fullpp_drain_tData", tData1, (j < 3) ? 32'(16'h00A1 + j) : 32'h00C7);
      step(0, 0, 16'h0, 1);
    end

    // Frame wrap: 24 streamed samples, tLast on transfers 8, 16, 24
    step(1, 0, 16'h0, 0);
    hsCount = 0; lastMask = '0;
    for (int k = 1; k <= 24; k++) step(0, 1, 16'(16'h0100 + k), 1);
    step(0, 0, 16'h0, 1);
    chk("wrap_hsCount", 32'(hsCount), 32'd24);
    chk("wrap_lastMask", lastMask, (32'h1 << 8) | (32'h1 << 16) | (32'h1 << 24));

    // Mid-frame reset after 3 handshakes, held two cycles with inputs active
    step(1, 0, 16'h0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 16'(k), 1);
      step(0, 0, 16'h0, 1);
    end
    for (int j = 0; j < 2; j++) begin
      step(1, 1, 16'hDEAD, 1);
      chk("rst_level0", 32'(level0), 32'h0);
      chk("rst_level1", 32'(level1), 32'h0);
      chk("rst_tValid", 32'(tValid0), 32'h0);
      chk("rst_tData", tData0, 32'h0);
      chk("rst_tLast", 32'(tLast0), 32'h0);
    end
    hsCount = 0; lastMask = '0;
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 16'(16'h0200 + k), 1);
      step(0, 0, 16'h0, 1);
    end
    chk("midrst_hsCount", 32'(hsCount), 32'd8);
    chk("midrst_lastMask", lastMask, 32'h1 << 8);

    // Randomised traffic with bursty backpressure and rare resets
    begin
      int rdyProb = 50;
      for (int c = 0; c < 1500; c++) begin
        if (c % 64 == 0) begin
          case ($urandom_range(0, 2))
            0:       rdyProb = 10;
            1:       rdyProb = 50;
            default: rdyProb = 95;
          endcase
        end
        step($urandom_range(0, 199) == 0,
             $urandom_range(0, 99) < 55,
             16'($urandom()),
             $urandom_range(0, 99) < rdyProb);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
